uart_rx: RTL and testbench

- 8N1-style asynchronous serial receiver; the receive counterpart of the UART transmitter.
- Samples `rxd` at mid-bit using the same bit-time rule as the transmitter: one bit = prescale*8 clk cycles.
- Presents received words on an AXI-Stream master interface with a single-entry output register.
- Flags framing and overrun errors.

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with mid-bit sampling and an AXI-Stream output register.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote at every sample point.
`timescale 1ns/1ps

module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  // state      | meaning
  // IDLE       | line idle, waiting for rxd_s low with prescale != 0
  // START      | timing to middle of start bit, rejects false starts
  // DATA       | sampling DATA_WIDTH data bits, LSB first
  // STOP       | timing to middle of stop bit
  // BREAK_WAIT | stop bit was low; wait for line to return high
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_n;
  logic                  rxd_m, rxd_s;
  logic [18:0]           cnt, cnt_n;
  logic [15:0]           p_lat, p_n;
  logic [IW-1:0]         bit_idx, idx_n;
  logic [DATA_WIDTH-1:0] shreg, sh_n;
  logic [DATA_WIDTH:0]   sh_tmp;
  logic [DATA_WIDTH-1:0] tdata_n;
  logic                  tvalid_n, ovr_n, ferr_n;
  logic                  samp, tick;
  logic [18:0]           bit_time, start_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rxd_d1, rxd_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_d1 <= 1'b1;
      rxd_d2 <= 1'b1;
    end else begin
      rxd_d1 <= rxd_s;
      rxd_d2 <= rxd_d1;
    end
  end

  // Decision is taken one cycle after the nominal point so that the
  // sample after it is available; the start load is one longer to match.
  assign samp       = (rxd_s & rxd_d1) | (rxd_s & rxd_d2) | (rxd_d1 & rxd_d2);
  assign start_load = {1'b0, prescale, 2'b00};
`else
  assign samp       = rxd_s;
  assign start_load = {1'b0, prescale, 2'b00} - 19'd1;
`endif

  assign tick     = (cnt == 19'd0);
  assign bit_time = {p_lat, 3'b000} - 19'd1;
  assign sh_tmp   = {samp, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      p_lat         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      p_lat         <= p_n;
      bit_idx       <= idx_n;
      shreg         <= sh_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      overrun_error <= ovr_n;
      frame_error   <= ferr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = tick ? cnt : cnt - 19'd1;
    p_n      = p_lat;
    idx_n    = bit_idx;
    sh_n     = shreg;
    tdata_n  = m_axis_tdata;
    tvalid_n = m_axis_tvalid & ~m_axis_tready;
    ovr_n    = 1'b0;
    ferr_n   = 1'b0;

    case (state)
      IDLE: begin
        if (!rxd_s && (prescale != 16'd0)) begin
          p_n     = prescale;
          cnt_n   = start_load;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (samp) begin
            state_n = IDLE;
          end else begin
            cnt_n   = bit_time;
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_n  = sh_tmp[DATA_WIDTH:1];
          cnt_n = bit_time;
          if (bit_idx == IW'(DATA_WIDTH - 1)) begin
            state_n = STOP;
          end else begin
            idx_n = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp) begin
            // A pending word that is not being accepted this cycle is lost.
            tdata_n  = shreg;
            tvalid_n = 1'b1;
            ovr_n    = m_axis_tvalid & ~m_axis_tready;
            state_n  = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        if (rxd_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Combinational so busy rises in the same cycle the start edge is seen.
  assign busy = (state != IDLE) | (~rxd_s & (prescale != 16'd0));

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: table of single frames plus
// hand-written sequences for false start, break, overrun, back-to-back and reset.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int W = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         rxd = 1'b1;
  logic         busy;
  logic         overrun_error;
  logic         frame_error;
  logic [15:0]  prescale = 16'd6;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge; cyc names the cycle being observed.
  logic         prev_v = 1'b0, prev_b = 1'b0;
  int           rise_cnt = 0, last_rise = -1;
  logic [W-1:0] last_tdata = '0;
  int           fe_cnt = 0, last_fe = -1, ov_cnt = 0, last_ov = -1, both_cnt = 0;
  int           hs_cnt = 0;
  logic [W-1:0] words [0:63];
  int           busy_rise_cnt = 0, busy_rise = -1, busy_fall = -1;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_b = 1'b0;
    end else begin
      if (m_axis_tvalid && !prev_v) begin
        rise_cnt++;
        last_rise  = cyc;
        last_tdata = m_axis_tdata;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        words[hs_cnt % 64] = m_axis_tdata;
        hs_cnt++;
      end
      if (frame_error) begin fe_cnt++; last_fe = cyc; end
      if (overrun_error) begin ov_cnt++; last_ov = cyc; end
      if (frame_error && overrun_error) both_cnt++;
      if (busy && !prev_b) begin busy_rise_cnt++; busy_rise = cyc; end
      if (!busy && prev_b) busy_fall = cyc;
      prev_v = m_axis_tvalid;
      prev_b = busy;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  // Leaves rxd at the stop value; callers return the line high with idle().
  task automatic send_frame(input int p, input logic [W-1:0] d, input logic stop_b, input int extra_low);
    hold(1'b0, 8 * p);
    for (int i = 0; i < W; i++) hold(d[i], 8 * p);
    hold(stop_b, 8 * p + (stop_b ? 0 : extra_low));
  endtask

  typedef struct {
    int           p;
    logic [W-1:0] d;
    int           lat;
    logic [W-1:0] exp_tdata;
  } vec_t;

  vec_t tbl [5];
  int   k, r, r0, f0, o0, h0, b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    // lat = 4P + 8P*9 + 1: start-of-frame to first tvalid cycle
    tbl[0] = '{p: 6, d: 8'h55, lat: 457, exp_tdata: 8'h55};
    tbl[1] = '{p: 1, d: 8'hA5, lat: 77,  exp_tdata: 8'hA5};
    tbl[2] = '{p: 2, d: 8'h01, lat: 153, exp_tdata: 8'h01};
    tbl[3] = '{p: 3, d: 8'h80, lat: 229, exp_tdata: 8'h80};
    tbl[4] = '{p: 5, d: 8'h3C, lat: 381, exp_tdata: 8'h3C};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_error, 0);
    check("rst_frame_err", frame_error, 0);
    rst = 1'b0;
    idle(10);

    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prescale = 16'(tbl[i].p);
      idle(20);
      r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; k = cyc;
      send_frame(tbl[i].p, tbl[i].d, 1'b1, 0);
      idle(20);
      check($sformatf("tbl%0d_words", i), rise_cnt - r0, 1);
      check($sformatf("tbl%0d_tdata", i), last_tdata, tbl[i].exp_tdata);
      check($sformatf("tbl%0d_valid_cyc", i), last_rise, k + 2 + tbl[i].lat + LAT);
      check($sformatf("tbl%0d_busy_rise", i), busy_rise, k + 2);
      check($sformatf("tbl%0d_busy_fall", i), busy_fall, k + 2 + tbl[i].lat + LAT);
      check($sformatf("tbl%0d_errors", i), (fe_cnt - f0) + (ov_cnt - o0), 0);
      check($sformatf("tbl%0d_valid_len", i), m_axis_tvalid, 0);
    end

    // False start: 10 low cycles are gone by the start sample at T0+24.
    prescale = 16'd6;
    idle(20);
    r0 = rise_cnt; f0 = fe_cnt; k = cyc;
    hold(1'b0, 10);
    idle(60);
    check("false_busy_rise", busy_rise, k + 2);
    check("false_busy_fall", busy_fall, k + 2 + 25 + LAT);
    check("false_words", rise_cnt - r0, 0);
    check("false_errors", fe_cnt - f0, 0);

    // Low stop bit followed by a held break.
    idle(20);
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; k = cyc;
    send_frame(6, 8'hA3, 1'b0, 200);
    check("brk_busy_held", busy, 1);
    r = cyc;
    idle(20);
    check("brk_fe_count", fe_cnt - f0, 1);
    check("brk_fe_cyc", last_fe, k + 2 + 457 + LAT);
    check("brk_busy_fall", busy_fall, r + 3);
    check("brk_no_word", rise_cnt - r0, 0);
    check("brk_no_overrun", ov_cnt - o0, 0);
    r0 = rise_cnt;
    send_frame(6, 8'h3C, 1'b1, 0);
    idle(20);
    check("brk_next_words", rise_cnt - r0, 1);
    check("brk_next_tdata", last_tdata, 8'h3C);

    // Overrun: two frames with nobody accepting.
    prescale = 16'd4;
    m_axis_tready = 1'b0;
    idle(20);
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; k = cyc;
    send_frame(4, 8'h11, 1'b1, 0);
    send_frame(4, 8'h22, 1'b1, 0);
    idle(10);
    check("ovr_rises", rise_cnt - r0, 1);
    check("ovr_first_cyc", last_rise, k + 2 + 305 + LAT);
    check("ovr_count", ov_cnt - o0, 1);
    check("ovr_cyc", last_ov, k + 2 + 320 + 305 + LAT);
    check("ovr_tdata", m_axis_tdata, 8'h22);
    check("ovr_tvalid", m_axis_tvalid, 1);
    check("ovr_no_fe", fe_cnt - f0, 0);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("hs_valid_same_cycle", m_axis_tvalid, 1);
    @(negedge clk);
    check("hs_valid_cleared", m_axis_tvalid, 0);
    @(posedge clk);
    #1;

    // Back-to-back frames, single stop bit each.
    idle(20);
    h0 = hs_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(4, 8'h00, 1'b1, 0);
    send_frame(4, 8'hFF, 1'b1, 0);
    send_frame(4, 8'h81, 1'b1, 0);
    idle(20);
    check("b2b_count", hs_cnt - h0, 3);
    check("b2b_word0", words[h0 % 64], 8'h00);
    check("b2b_word1", words[(h0 + 1) % 64], 8'hFF);
    check("b2b_word2", words[(h0 + 2) % 64], 8'h81);
    check("b2b_errors", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // Reset in the middle of data bit 3 of 0x5A.
    prescale = 16'd6;
    idle(20);
    r0 = rise_cnt;
    hold(1'b0, 48);
    hold(1'b0, 48);
    hold(1'b1, 48);
    hold(1'b0, 48);
    hold(1'b1, 20);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {frame_error, overrun_error}, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(40);
    check("mid_rst_no_word", rise_cnt - r0, 0);
    send_frame(6, 8'h96, 1'b1, 0);
    idle(20);
    check("post_rst_words", rise_cnt - r0, 1);
    check("post_rst_tdata", last_tdata, 8'h96);

    // prescale == 0 ignores the line.
    prescale = 16'd0;
    idle(5);
    b0 = busy_rise_cnt; r0 = rise_cnt;
    hold(1'b0, 60);
    idle(20);
    check("p0_no_busy", busy_rise_cnt - b0, 0);
    check("p0_no_word", rise_cnt - r0, 0);

    check("errors_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
